// File: rtl/axi3_apb_write_bridge_pkg.sv
// Shared constants and state encoding for the AXI3-write to APB bridge.
package axi_apb_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } bridge_state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        case (len)
            4'd1, 4'd3, 4'd7, 4'd15: wrap_len_ok = 1'b1;
            default:                 wrap_len_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi3_apb_write_bridge_if.sv
// AXI3 write channels plus APB master signals for the write bridge.
// slave modport is the bridge side; master modport is the traffic/responder side.
interface axi3_apb_write_bridge_if #(parameter int APB_ADDR_W = 16);
    logic [31:0]           AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic                  WLAST;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [APB_ADDR_W-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        input  WDATA, WSTRB, WVALID, WLAST, BREADY, PREADY, PSLVERR,
        output AWREADY, WREADY, BRESP, BVALID,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
    );

    modport master (
        output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        output WDATA, WSTRB, WVALID, WLAST, BREADY, PREADY, PSLVERR,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
    );
endinterface

// File: rtl/axi3_apb_write_bridge_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi3_burst_addr_gen
    import axi_apb_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);
    logic [31:0] bytes;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    always_comb begin
        bytes     = 32'd1 << size;
        incr_addr = addr + bytes;
        wrap_mask = ((({28'd0, len}) + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end
endmodule

// File: rtl/axi3_apb_write_bridge.sv
// AXI3 write-only slave issuing one APB write per W beat, single B response per burst.
// Optional APB_TIMEOUT_EN adds a PREADY watchdog of TIMEOUT_CYCLES in ACCESS.
module axi3_apb_write_bridge
    import axi_apb_pkg::*;
#(
    parameter int APB_ADDR_W = 16
`ifdef APB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input logic ACLK,
    input logic ARESET,
    axi3_apb_write_bridge_if.slave bus
);
    // state  | meaning
    // IDLE   | AWREADY high, waiting for a burst
    // WDATA  | WREADY high, waiting for the next beat
    // SETUP  | APB setup phase (PSEL=1, PENABLE=0)
    // ACCESS | APB access phase, waiting for PREADY
    // RESP   | BVALID high with accumulated error
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_WDATA  = ST_WDATA;
    localparam logic [2:0] S_SETUP  = ST_SETUP;
    localparam logic [2:0] S_ACCESS = ST_ACCESS;
    localparam logic [2:0] S_RESP   = ST_RESP;

    logic [2:0]  state;
    logic [31:0] addr;
    logic [31:0] next_addr;
    logic [3:0]  len;
    logic [3:0]  beat;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  aw_burst;
    logic        aw_err;
    logic        psel;
    logic        size_err;
    logic        last_beat;
    logic        beat_done;
    logic        beat_err;

    // Illegal burst encodings fall back to INCR but flag the response.
    always_comb begin
        aw_burst = bus.AWBURST;
        aw_err   = (bus.AWSIZE > 3'd2);
        if (bus.AWBURST == 2'b11) begin
            aw_burst = BURST_INCR;
            aw_err   = 1'b1;
        end else if (bus.AWBURST == BURST_WRAP && !wrap_len_ok(bus.AWLEN)) begin
            aw_burst = BURST_INCR;
            aw_err   = 1'b1;
        end
    end

    assign size_err  = (size > 3'd2);
    assign last_beat = (beat == len);

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit   = (state == S_ACCESS) && !bus.PREADY && (tmo_cnt == '0);
    assign beat_done = bus.PREADY || tmo_hit;
    assign beat_err  = bus.PREADY ? bus.PSLVERR : 1'b1;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tmo_cnt <= '0;
        end else if (state == S_SETUP) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (state == S_ACCESS && !bus.PREADY && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
`else
    assign beat_done = bus.PREADY;
    assign beat_err  = bus.PSLVERR;
`endif

    axi3_burst_addr_gen u_addr_gen (
        .addr      (addr),
        .len       (len),
        .size      (size),
        .burst     (burst),
        .next_addr (next_addr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= S_IDLE;
            addr  <= '0;
            len   <= '0;
            size  <= '0;
            burst <= BURST_FIXED;
            beat  <= '0;
            err   <= 1'b0;
            wdata <= '0;
            wstrb <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.AWVALID) begin
                    addr  <= bus.AWADDR;
                    len   <= bus.AWLEN;
                    size  <= bus.AWSIZE;
                    burst <= aw_burst;
                    beat  <= '0;
                    err   <= aw_err;
                    state <= S_WDATA;
                end
                S_WDATA: if (bus.WVALID) begin
                    wdata <= bus.WDATA;
                    wstrb <= bus.WSTRB;
                    if (bus.WLAST != last_beat) err <= 1'b1;
                    // Oversized beats are drained without touching APB.
                    if (!size_err) begin
                        state <= S_SETUP;
                    end else if (last_beat) begin
                        state <= S_RESP;
                    end else begin
                        beat <= beat + 4'd1;
                        addr <= next_addr;
                    end
                end
                S_SETUP: state <= S_ACCESS;
                S_ACCESS: if (beat_done) begin
                    if (beat_err) err <= 1'b1;
                    if (last_beat) begin
                        state <= S_RESP;
                    end else begin
                        beat  <= beat + 4'd1;
                        addr  <= next_addr;
                        state <= S_WDATA;
                    end
                end
                S_RESP: if (bus.BREADY) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign psel        = (state == S_SETUP) || (state == S_ACCESS);
    assign bus.AWREADY = (state == S_IDLE);
    assign bus.WREADY  = (state == S_WDATA);
    assign bus.BVALID  = (state == S_RESP);
    assign bus.BRESP   = ((state == S_RESP) && err) ? RESP_SLVERR : RESP_OKAY;
    assign bus.PSEL    = psel;
    assign bus.PENABLE = (state == S_ACCESS);
    assign bus.PWRITE  = psel;
    assign bus.PADDR   = psel ? addr[APB_ADDR_W-1:0] : '0;
    assign bus.PWDATA  = psel ? wdata : '0;
    assign bus.PSTRB   = psel ? wstrb : '0;
endmodule

// File: tb/tb_axi3_apb_write_bridge.sv
// Directed self-checking bench for axi3_apb_write_bridge with an inline APB responder.
module tb_axi3_apb_write_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    axi3_apb_write_bridge_if #(.APB_ADDR_W(16)) bus ();

    axi3_apb_write_bridge #(.APB_ADDR_W(16)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [15:0] obs_addr [16];
    logic [31:0] obs_data [16];
    logic [3:0]  obs_strb [16];
    int          n_apb;
    logic        obs_wready_lat, obs_setup_ok, obs_access_ok;
    logic        obs_bvalid_lat, obs_psel_stray, obs_idle_after;
    logic [1:0]  obs_bresp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flag(input string name, ref logic flag);
        int guard = 0;
        while (flag !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        if (flag !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s handshake timeout got 0 want 1", name);
        end
    endtask

    // Drives one burst and plays the APB slave; results land in obs_* for the tests to check.
    task automatic run_burst(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                             input int bad_last, input logic [15:0] slverr_mask, input int wait_cycles);
        bit apb;
        n_apb = 0;
        obs_wready_lat = 0; obs_setup_ok = 1; obs_access_ok = 1;
        obs_bvalid_lat = 0; obs_psel_stray = 0; obs_idle_after = 0; obs_bresp = 2'bxx;
        apb = (size <= 3'd2);
        bus.AWADDR = a; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1;
        wait_flag("awready", bus.AWREADY);
        step();
        bus.AWVALID = 0;
        obs_wready_lat = bus.WREADY;
        for (int b = 0; b <= int'(len); b++) begin
            bus.WDATA = d0 + b; bus.WSTRB = strb;
            bus.WLAST = (b == int'(len)) ^ (b == bad_last);
            bus.WVALID = 1;
            wait_flag("wready", bus.WREADY);
            step();
            bus.WVALID = 0; bus.WLAST = 0;
            if (!apb) begin
                if (bus.PSEL) obs_psel_stray = 1;
            end else begin
                if (!(bus.PSEL && !bus.PENABLE && bus.PWRITE)) obs_setup_ok = 0;
                obs_addr[n_apb] = bus.PADDR;
                obs_data[n_apb] = bus.PWDATA;
                obs_strb[n_apb] = bus.PSTRB;
                step();
                for (int w = 0; w <= wait_cycles; w++) begin
                    if (!(bus.PSEL && bus.PENABLE && bus.PWRITE) || bus.PADDR !== obs_addr[n_apb] ||
                        bus.PWDATA !== obs_data[n_apb] || bus.PSTRB !== obs_strb[n_apb])
                        obs_access_ok = 0;
                    if (w == wait_cycles) begin
                        bus.PREADY = 1;
                        bus.PSLVERR = slverr_mask[b];
                    end
                    step();
                end
                bus.PREADY = 0; bus.PSLVERR = 0;
                n_apb++;
            end
        end
        obs_bvalid_lat = bus.BVALID;
        bus.BREADY = 1;
        wait_flag("bvalid", bus.BVALID);
        obs_bresp = bus.BRESP;
        step();
        bus.BREADY = 0;
        obs_idle_after = bus.AWREADY && !bus.BVALID;
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready got %b want 1", bus.AWREADY); end
        checks++; if (bus.WREADY !== 1'b0) begin errors++; $display("FAIL reset_wready got %b want 0", bus.WREADY); end
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl got %b want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        checks++; if ({bus.BVALID, bus.BRESP} !== 3'b000) begin errors++; $display("FAIL reset_b got %b want 000", {bus.BVALID, bus.BRESP}); end
        checks++; if ({bus.PADDR, bus.PWDATA, bus.PSTRB} !== 52'd0) begin errors++; $display("FAIL reset_apb_data got %h want 0", {bus.PADDR, bus.PWDATA, bus.PSTRB}); end
        rst = 0;
        step();
    endtask

    task automatic test_single();
        run_burst(32'h1000_0040, 4'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, -1, 16'h0, 0);
        checks++; if (n_apb !== 1) begin errors++; $display("FAIL single_count got %0d want 1", n_apb); end
        checks++; if (obs_addr[0] !== 16'h0040) begin errors++; $display("FAIL single_paddr got %h want 0040", obs_addr[0]); end
        checks++; if (obs_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_pwdata got %h want deadbeef", obs_data[0]); end
        checks++; if (obs_strb[0] !== 4'hF) begin errors++; $display("FAIL single_pstrb got %h want f", obs_strb[0]); end
        checks++; if (obs_wready_lat !== 1'b1) begin errors++; $display("FAIL single_wready_latency got %b want 1", obs_wready_lat); end
        checks++; if ({obs_setup_ok, obs_access_ok} !== 2'b11) begin errors++; $display("FAIL single_apb_phases got %b want 11", {obs_setup_ok, obs_access_ok}); end
        checks++; if (obs_bvalid_lat !== 1'b1) begin errors++; $display("FAIL single_bvalid_latency got %b want 1", obs_bvalid_lat); end
        checks++; if (obs_bresp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b want 00", obs_bresp); end
        checks++; if (obs_idle_after !== 1'b1) begin errors++; $display("FAIL single_idle_after got %b want 1", obs_idle_after); end
    endtask

    task automatic test_incr();
        run_burst(32'h1000_0100, 4'd3, 3'd2, 2'b01, 32'h1234_0000, 4'h3, -1, 16'h0, 0);
        checks++; if (n_apb !== 4) begin errors++; $display("FAIL incr_count got %0d want 4", n_apb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== 16'h0100 + 16'(4 * i) || obs_data[i] !== 32'h1234_0000 + i || obs_strb[i] !== 4'h3) begin
                errors++;
                $display("FAIL incr_beat%0d got %h/%h/%h want %h/%h/3", i, obs_addr[i], obs_data[i], obs_strb[i], 16'h0100 + 16'(4 * i), 32'h1234_0000 + i);
            end
        end
        checks++; if (obs_bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b want 00", obs_bresp); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp [4];
        exp[0] = 16'h0038; exp[1] = 16'h003C; exp[2] = 16'h0030; exp[3] = 16'h0034;
        run_burst(32'h1000_0038, 4'd3, 3'd2, 2'b10, 32'hAA00_0000, 4'hF, -1, 16'h0, 0);
        checks++; if (n_apb !== 4) begin errors++; $display("FAIL wrap_count got %0d want 4", n_apb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_addr[i] !== exp[i]) begin errors++; $display("FAIL wrap_paddr%0d got %h want %h", i, obs_addr[i], exp[i]); end
        end
        checks++; if (obs_bresp !== 2'b00) begin errors++; $display("FAIL wrap_bresp got %b want 00", obs_bresp); end
    endtask

    task automatic test_slverr();
        run_burst(32'h1000_0200, 4'd1, 3'd2, 2'b01, 32'h5500_0000, 4'hF, -1, 16'h0001, 0);
        checks++; if (n_apb !== 2 || obs_addr[1] !== 16'h0204) begin errors++; $display("FAIL slverr_second_beat got %0d/%h want 2/0204", n_apb, obs_addr[1]); end
        checks++; if (obs_bresp !== 2'b10) begin errors++; $display("FAIL slverr_bresp got %b want 10", obs_bresp); end
    endtask

    task automatic test_wlast();
        run_burst(32'h1000_0300, 4'd2, 3'd2, 2'b01, 32'h0, 4'hF, 0, 16'h0, 0);
        checks++; if (n_apb !== 3) begin errors++; $display("FAIL wlast_count got %0d want 3", n_apb); end
        checks++; if (obs_bresp !== 2'b10) begin errors++; $display("FAIL wlast_bresp got %b want 10", obs_bresp); end
    endtask

    task automatic test_size_err();
        run_burst(32'h1000_0000, 4'd1, 3'd3, 2'b01, 32'h0, 4'hF, -1, 16'h0, 0);
        checks++; if (obs_psel_stray !== 1'b0) begin errors++; $display("FAIL size_err_psel got %b want 0", obs_psel_stray); end
        checks++; if (obs_bvalid_lat !== 1'b1 || obs_bresp !== 2'b10) begin errors++; $display("FAIL size_err_bresp got %b/%b want 1/10", obs_bvalid_lat, obs_bresp); end
    endtask

    task automatic test_burst_types();
        run_burst(32'h1000_0400, 4'd1, 3'd2, 2'b11, 32'h0, 4'hF, -1, 16'h0, 0);
        checks++; if (obs_addr[0] !== 16'h0400 || obs_addr[1] !== 16'h0404 || obs_bresp !== 2'b10) begin errors++; $display("FAIL reserved_burst got %h,%h,%b want 0400,0404,10", obs_addr[0], obs_addr[1], obs_bresp); end
        run_burst(32'h1000_0508, 4'd2, 3'd2, 2'b10, 32'h0, 4'hF, -1, 16'h0, 0);
        checks++; if (obs_addr[2] !== 16'h0510 || obs_bresp !== 2'b10) begin errors++; $display("FAIL wrap_badlen got %h,%b want 0510,10", obs_addr[2], obs_bresp); end
        run_burst(32'h1000_0600, 4'd2, 3'd1, 2'b00, 32'h0, 4'h3, -1, 16'h0, 0);
        checks++; if (obs_addr[0] !== 16'h0600 || obs_addr[2] !== 16'h0600 || obs_bresp !== 2'b00) begin errors++; $display("FAIL fixed got %h,%h,%b want 0600,0600,00", obs_addr[0], obs_addr[2], obs_bresp); end
        run_burst(32'h1FFF_FFFF, 4'd1, 3'd0, 2'b01, 32'h0, 4'h1, -1, 16'h0, 0);
        checks++; if (obs_addr[0] !== 16'hFFFF || obs_addr[1] !== 16'h0000 || obs_bresp !== 2'b00) begin errors++; $display("FAIL incr_byte_wrap got %h,%h,%b want ffff,0000,00", obs_addr[0], obs_addr[1], obs_bresp); end
    endtask

    task automatic test_stall();
        run_burst(32'h1000_0080, 4'd0, 3'd2, 2'b01, 32'hCAFE_F00D, 4'h6, -1, 16'h0, 5);
        checks++; if (obs_access_ok !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", obs_access_ok); end
        checks++; if (obs_bresp !== 2'b00 || obs_bvalid_lat !== 1'b1) begin errors++; $display("FAIL stall_bresp got %b/%b want 00/1", obs_bresp, obs_bvalid_lat); end
    endtask

    task automatic test_timeout();
`ifdef APB_TIMEOUT_EN
        int acc = 0;
        int guard = 0;
        bus.AWADDR = 32'h1000_0900; bus.AWLEN = 0; bus.AWSIZE = 2; bus.AWBURST = 2'b01; bus.AWVALID = 1;
        wait_flag("awready", bus.AWREADY);
        step(); bus.AWVALID = 0;
        bus.WDATA = 32'h1; bus.WSTRB = 4'hF; bus.WLAST = 1; bus.WVALID = 1;
        wait_flag("wready", bus.WREADY);
        step(); bus.WVALID = 0; bus.WLAST = 0;
        while (!bus.BVALID && guard < 400) begin
            step();
            if (bus.PENABLE) acc++;
            guard++;
        end
        checks++; if (acc !== 256) begin errors++; $display("FAIL timeout_access_cycles got %0d want 256", acc); end
        checks++; if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b10) begin errors++; $display("FAIL timeout_bresp got %b/%b want 1/10", bus.BVALID, bus.BRESP); end
        bus.BREADY = 1; step(); bus.BREADY = 0;
`else
        run_burst(32'h1000_0900, 4'd0, 3'd2, 2'b01, 32'h1, 4'hF, -1, 16'h0, 300);
        checks++; if (obs_access_ok !== 1'b1) begin errors++; $display("FAIL no_timeout_hold got %b want 1", obs_access_ok); end
        checks++; if (obs_bresp !== 2'b00) begin errors++; $display("FAIL no_timeout_bresp got %b want 00", obs_bresp); end
`endif
    endtask

    task automatic test_reset_mid();
        bus.AWADDR = 32'h1000_0700; bus.AWLEN = 1; bus.AWSIZE = 2; bus.AWBURST = 2'b01; bus.AWVALID = 1;
        wait_flag("awready", bus.AWREADY);
        step(); bus.AWVALID = 0;
        bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WLAST = 0; bus.WVALID = 1;
        wait_flag("wready", bus.WREADY);
        step(); bus.WVALID = 0;
        step(); step(); step();
        checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL reset_mid_in_access got %b want 1", bus.PENABLE); end
        rst = 1;
        step();
        checks++; if ({bus.PSEL, bus.PENABLE, bus.AWREADY} !== 3'b001) begin errors++; $display("FAIL reset_mid_drop got %b want 001", {bus.PSEL, bus.PENABLE, bus.AWREADY}); end
        checks++; if (bus.PADDR !== 16'h0) begin errors++; $display("FAIL reset_mid_paddr got %h want 0000", bus.PADDR); end
        rst = 0;
        step();
        run_burst(32'h1000_0044, 4'd0, 3'd2, 2'b01, 32'h0BAD_F00D, 4'h8, -1, 16'h0, 1);
        checks++; if (n_apb !== 1 || obs_addr[0] !== 16'h0044 || obs_bresp !== 2'b00) begin errors++; $display("FAIL reset_mid_recover got %0d/%h/%b want 1/0044/00", n_apb, obs_addr[0], obs_bresp); end
    endtask

    initial begin
        bus.AWADDR = 0; bus.AWVALID = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0;
        bus.WDATA = 0; bus.WSTRB = 0; bus.WVALID = 0; bus.WLAST = 0; bus.BREADY = 0;
        bus.PREADY = 0; bus.PSLVERR = 0;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_slverr();
        test_wlast();
        test_size_err();
        test_burst_types();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
